// File: rtl/song_timer.sv
// Track-time controller on the 1 Hz tick: latches song length, counts elapsed play
// time, and registers remaining time (binary and BCD), percent progress and the finish pulse.
module song_timer #(
  parameter int unsigned MAX_MIN = 99
) (
  input  logic        clk_second,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  len_min,
  input  logic [7:0]  len_sec,
  input  logic        play,
  input  logic        repeat_en,
  output logic        o_finish_song,
  output logic [1:0]  state,
  output logic [7:0]  elapsed_min,
  output logic [7:0]  elapsed_sec,
  output logic [7:0]  remain_min,
  output logic [7:0]  remain_sec,
  output logic [15:0] remain_bcd,
  output logic [6:0]  progress
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  localparam logic [7:0] MAX_MIN_L = 8'(MAX_MIN);

  // Handshake: none. load/play/repeat_en are levels sampled on every rising
  // clk_second edge; o_finish_song is a one-cycle registered pulse.

  state_e      state_q, state_d;
  logic [12:0] len_total_q, len_total_d;
  logic [12:0] elapsed_total_q, elapsed_total_d;
  logic        finish_q, finish_d;

  logic [7:0]  min_clamped, sec_clamped;
  logic [12:0] len_clamped;
  logic [12:0] elapsed_inc;

  always_comb begin
    min_clamped = (len_min > MAX_MIN_L) ? MAX_MIN_L : len_min;
    sec_clamped = (len_sec > 8'd59) ? 8'd59 : len_sec;
    len_clamped = {5'd0, min_clamped} * 13'd60 + {5'd0, sec_clamped};
    elapsed_inc = elapsed_total_q + 13'd1;
  end

  always_comb begin
    state_d         = state_q;
    len_total_d     = len_total_q;
    elapsed_total_d = elapsed_total_q;
    finish_d        = 1'b0;
    if (load) begin
      len_total_d     = len_clamped;
      elapsed_total_d = 13'd0;
      if (len_clamped == 13'd0) state_d = S_IDLE;
      else if (play)            state_d = S_PLAY;
      else                      state_d = S_PAUSE;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (!play) begin
            state_d = S_PAUSE;
          end else if (elapsed_inc == len_total_q) begin
            finish_d = 1'b1;
            if (repeat_en) begin
              elapsed_total_d = 13'd0;
            end else begin
              elapsed_total_d = len_total_q;
              state_d         = S_DONE;
            end
          end else begin
            elapsed_total_d = elapsed_inc;
          end
        end
        S_PAUSE: if (play) state_d = S_PLAY;
        default: ;
      endcase
    end
  end

  // Display values are computed from the next-state totals so the output
  // registers always agree with the counters after the same edge.
  logic [12:0] remain_total_d;
  logic [7:0]  el_min_d, el_sec_d, rm_min_d, rm_sec_d;
  logic [15:0] bcd_d;
  logic [19:0] prod_d;
  logic [6:0]  progress_d;

  always_comb begin
    remain_total_d = len_total_d - elapsed_total_d;
    el_min_d = 8'(elapsed_total_d / 13'd60);
    el_sec_d = 8'(elapsed_total_d % 13'd60);
    rm_min_d = 8'(remain_total_d / 13'd60);
    rm_sec_d = 8'(remain_total_d % 13'd60);
    bcd_d    = {4'(rm_min_d / 8'd10), 4'(rm_min_d % 8'd10),
                4'(rm_sec_d / 8'd10), 4'(rm_sec_d % 8'd10)};
    prod_d   = 20'(elapsed_total_d) * 20'd100;
    if (len_total_d == 13'd0) progress_d = 7'd0;
    else                      progress_d = 7'(prod_d / 20'(len_total_d));
  end

  always_ff @(posedge clk_second or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      len_total_q     <= 13'd0;
      elapsed_total_q <= 13'd0;
      finish_q        <= 1'b0;
      elapsed_min     <= 8'd0;
      elapsed_sec     <= 8'd0;
      remain_min      <= 8'd0;
      remain_sec      <= 8'd0;
      remain_bcd      <= 16'h0000;
      progress        <= 7'd0;
    end else begin
      state_q         <= state_d;
      len_total_q     <= len_total_d;
      elapsed_total_q <= elapsed_total_d;
      finish_q        <= finish_d;
      elapsed_min     <= el_min_d;
      elapsed_sec     <= el_sec_d;
      remain_min      <= rm_min_d;
      remain_sec      <= rm_sec_d;
      remain_bcd      <= bcd_d;
      progress        <= progress_d;
    end
  end

  assign o_finish_song = finish_q;
  assign state         = state_q;

endmodule

// File: doc/song_timer.md
# song_timer

Track-time controller clocked by the 1 Hz second tick. It latches the current song length, counts elapsed play time while playing and holds it while paused. It derives remaining time (binary and BCD) and percent progress, and raises `o_finish_song` when the track ends. It sits beside the elapsed-time counter in the player: its `o_finish_song` feeds that counter's `i_finish_song` clear and the track sequencer's auto-advance input.

## Interface
- `MAX_MIN`, default 99: maximum accepted `len_min`. A load with a larger value is clamped to `MAX_MIN`.
- `clk_second`  in  1  1 Hz tick clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `load`  in  1  level; upstream holds it ≥1 `clk_second` period when a new track starts (next/pre/auto-advance).
- `len_min`  in  8  track length, minutes (0..`MAX_MIN`).
- `len_sec`  in  8  track length, seconds (0..59; values >59 clamped to 59).
- `play`  in  1  1 = play, 0 = pause; level.
- `repeat_en`  in  1  1 = restart the same track at its end instead of stopping.
- `o_finish_song`  out  1  registered end-of-track pulse, one `clk_second` cycle.
- `state`  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 DONE.
- `elapsed_min`, `elapsed_sec`  out  8 each  elapsed time.
- `remain_min`, `remain_sec`  out  8 each  `len - elapsed`.
- `remain_bcd`  out  16  remaining time as BCD {M tens, M units, S tens, S units}.
- `progress`  out  7  floor(elapsed·100/len), 0..100.

## Operation
- Internal registers:
  - `len_total` is 13 bits, = `len_min`·60 + `len_sec`, max 5999.
  - `elapsed_total` is 13 bits.
  - All outputs are registered and derived from the post-edge values of these registers.
- `load` = 1 has priority over every other condition:
  - `len_total` ← clamped length.
  - `elapsed_total` ← 0. `o_finish_song` ← 0. `progress` ← 0.
  - `state` ← PLAY if `play` = 1, else PAUSE.
  - If the clamped length is 0, `state` ← IDLE and all time outputs are 0.
- IDLE: holds all values. Exits only on `load`.
- PLAY, `play` = 1:
  - `elapsed_total` ← `elapsed_total` + 1.
  - If the new value equals `len_total`, `o_finish_song` ← 1 and then:
    - `repeat_en` = 1: `elapsed_total` ← 0, stay in PLAY, progress ← 0.
    - `repeat_en` = 0: `state` ← DONE, `elapsed_total` = `len_total`, remaining 0, `progress` 100.
- PLAY, `play` = 0: `state` ← PAUSE. No increment on that edge.
- PAUSE:
  - `play` = 1: `state` ← PLAY. No increment on that edge; counting resumes on the next edge.
  - `play` = 0: hold.
- DONE: holds all values. Exits only on `load`. `play` and `repeat_en` are ignored.
- `o_finish_song` returns to 0 on the edge after it was asserted. With `len_total` = 1 and `repeat_en` = 1 it is legitimately high every cycle.
- Arithmetic:
  - minutes = `elapsed_total`/60, seconds = `elapsed_total`%60.
  - Remaining = `len_total` − `elapsed_total`, never negative.
  - `progress` uses a 20-bit product. Division is combinational; a 1 Hz clock gives unlimited slack.
  - BCD digits by /10 and %10 or double-dabble; minutes up to 99 are exact.

## Timing
- Reset (async, immediate):
  - `state` = IDLE, `o_finish_song` = 0, `len_total` = 0.
  - All time outputs 0, `remain_bcd` = 0x0000, `progress` = 0.
- Latency: input sampled on edge N appears on outputs after edge N, one-cycle registered. No combinational input-to-output paths.
- `load` held for k edges: elapsed stays 0 for all k edges. The first increment occurs on the first edge with `load` = 0 and `state` = PLAY.
- `rst_n` asserted mid-track: everything returns to reset values. After release, the block waits for `load`.
- Simultaneous `load` and end-of-track on the same edge: `load` wins and no finish pulse is generated.
- Pause on the final second: no finish pulse until play resumes and the next increment reaches `len_total`.

## Test plan
- Reset, then load 0:03 with `play` = 1, then 3 edges:
  - `elapsed_sec` goes 1, 2, 3.
  - `progress` goes 33, 66, 100.
  - `o_finish_song` high only after edge 3; `state` = DONE; `remain_bcd` = 0x0000.
- Load 1:05, play 61 edges:
  - `elapsed` shows 0:59 then 1:00 then 1:01 (seconds wrap).
  - `remain_bcd` = 0x0004 after 61 edges.
  - `progress` = 93.
- Load 0:10, play 4 edges, `play` = 0 for 5 edges, `play` = 1 for 2 edges: `elapsed_sec` = 5 (pause holds; resume edge does not count).
- `repeat_en` = 1, load 0:02, play 5 edges:
  - Finish pulses after edges 2 and 4.
  - `elapsed_sec` sequence 1, 0, 1, 0, 1; `state` remains PLAY.
- Load 0:00 → `state` = IDLE and outputs stay 0. Load 120:00 → clamped to 99:00, `remain_bcd` = 0x9900.
- Mid-track events:
  - Mid-track `load` of 0:30 → `elapsed` 0, `remain_bcd` = 0x0030.
  - Async `rst_n` low between edges → outputs zero immediately, no clock needed.
  - `load` on the final-second edge → no finish pulse.
